// File: rtl/btn_step_gen.sv
// Button conditioner: sync, debounce and decode two raw buttons
// into single-cycle step pulses with optional auto-repeat.
module btn_step_gen #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic       step_left,
  output logic       step_right,
  output logic [1:0] held,
  output logic       conflict
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PER   = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam bit            REP_EN  = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    IDLE, HOLD_L, HOLD_R, LOCKOUT
  } state_t;

  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_db;
  logic [DW-1:0] r_db_cnt [2];
  logic [RW-1:0] r_rep;
  state_t        r_state;
  logic          w_same;

  assign held = r_db;

  // bit 1 carries btn1 (left), bit 0 carries btn2 (right)
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {btn1, btn2};
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_db <= 2'b00;
      for (int i = 0; i < 2; i++)
        r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_same = (r_state == HOLD_L) ? (held == 2'b10)
                                      : (held == 2'b01);

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state    <= IDLE;
      r_rep      <= '0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      step_left  <= 1'b0;
      step_right <= 1'b0;
      unique case (r_state)
        IDLE: begin
          unique case (held)
            2'b10: begin
              step_left <= 1'b1;
              r_state   <= HOLD_L;
              r_rep     <= R_DELAY;
            end
            2'b01: begin
              step_right <= 1'b1;
              r_state    <= HOLD_R;
              r_rep      <= R_DELAY;
            end
            2'b11: begin
              r_state  <= LOCKOUT;
              conflict <= 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
        HOLD_L, HOLD_R: begin
          if (held == 2'b11) begin
            r_state  <= LOCKOUT;
            conflict <= 1'b1;
          end else if (held == 2'b00) begin
            r_state <= IDLE;
          end else if (!w_same) begin
            step_left  <= held[1];
            step_right <= held[0];
            r_state    <= held[1] ? HOLD_L : HOLD_R;
            r_rep      <= R_DELAY;
          end else if (REP_EN && r_rep <= R_ONE) begin
            // pulse on the cycle the count would hit zero
            step_left  <= held[1];
            step_right <= held[0];
            r_rep      <= R_PER;
          end else if (r_rep != '0) begin
            r_rep <= r_rep - 1'b1;
          end
        end
        LOCKOUT: begin
          if (held == 2'b00) begin
            r_state  <= IDLE;
            conflict <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_step_gen.sv
// Bench for btn_step_gen: two instances (repeat off / on) share
// stimulus; a scoreboard checks every step pulse by cycle and direction.
module tb_btn_step_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn1, btn2;
  logic       a_sl, a_sr, a_cf, b_sl, b_sr, b_cf;
  logic [1:0] a_held, b_held;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         q [2][$];
  logic [1:0] w_sl, w_sr;

  btn_step_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
  ) dut_a (
    .clk(clk), ._rst(rst_n), .btn1(btn1), .btn2(btn2),
    .step_left(a_sl), .step_right(a_sr),
    .held(a_held), .conflict(a_cf)
  );

  btn_step_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_b (
    .clk(clk), ._rst(rst_n), .btn1(btn1), .btn2(btn2),
    .step_left(b_sl), .step_right(b_sr),
    .held(b_held), .conflict(b_cf)
  );

  assign w_sl = {b_sl, a_sl};
  assign w_sr = {b_sr, a_sr};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               nm, cyc, got, exp);
    end
  endtask

  task automatic expect_pulse(input int d, input int c, input bit left);
    q[d].push_back(c * 2 + int'(left));
  endtask

  task automatic both(input int c, input bit left);
    expect_pulse(0, c, left);
    expect_pulse(1, c, left);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // entry = cycle*2 + (1 for left, 0 for right)
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      while (q[d].size() > 0 && q[d][0] / 2 < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_pulse dut%0d: no pulse, expected cyc %0d dir %0d",
                 d, q[d][0] / 2, q[d][0] % 2);
        void'(q[d].pop_front());
      end
      if (w_sl[d] || w_sr[d]) begin
        if (w_sl[d] && w_sr[d]) begin
          chk("overlap", 1, 0);
        end else if (q[d].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse dut%0d: got L=%0b R=%0b at cyc %0d, expected none",
                   d, w_sl[d], w_sr[d], cyc);
        end else begin
          chk($sformatf("pulse_dut%0d", d),
              cyc * 2 + int'(w_sl[d]), q[d].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    btn1  = 1'b0;
    btn2  = 1'b0;
    @(negedge clk);
    chk("rst_held_a", int'(a_held), 0);
    chk("rst_held_b", int'(b_held), 0);
    chk("rst_conf_a", int'(a_cf), 0);
    chk("rst_step_b", int'({b_sl, b_sr}), 0);
    wait_to(3);
    rst_n = 1'b1;

    // single press, repeat off on a, on in b
    wait_to(10);
    btn1 = 1'b1;
    both(17, 1'b1);
    expect_pulse(1, 27, 1'b1);
    expect_pulse(1, 30, 1'b1);
    expect_pulse(1, 33, 1'b1);
    expect_pulse(1, 36, 1'b1);
    wait_to(15);
    chk("latency_held_pre", int'(a_held), 0);
    wait_to(16);
    chk("latency_held", int'(a_held), 2);
    wait_to(30);
    btn1 = 1'b0;
    wait_to(37);
    chk("release_held", int'(b_held), 0);

    // short glitches on btn2
    for (int i = 0; i < 5; i++) begin
      wait_to(50 + 4 * i);
      btn2 = 1'b1;
      wait_to(53 + 4 * i);
      btn2 = 1'b0;
      chk("glitch_held", int'(a_held), 0);
    end
    wait_to(75);
    chk("glitch_final", int'(b_held), 0);

    // auto-repeat on btn2
    wait_to(80);
    btn2 = 1'b1;
    both(87, 1'b0);
    expect_pulse(1, 97, 1'b0);
    for (int k = 100; k <= 115; k += 3)
      expect_pulse(1, k, 1'b0);
    wait_to(86);
    chk("repeat_held", int'(b_held), 1);
    wait_to(110);
    btn2 = 1'b0;

    // both-pressed lockout
    wait_to(130);
    btn1 = 1'b1;
    both(137, 1'b1);
    wait_to(140);
    btn2 = 1'b1;
    wait_to(146);
    chk("both_held", int'(a_held), 3);
    wait_to(147);
    chk("conf_on_a", int'(a_cf), 1);
    chk("conf_on_b", int'(b_cf), 1);
    wait_to(150);
    btn1 = 1'b0;
    wait_to(156);
    chk("lock_held_r", int'(a_held), 1);
    chk("lock_conf", int'(a_cf), 1);
    wait_to(160);
    btn2 = 1'b0;
    wait_to(166);
    chk("lock_conf_last", int'(b_cf), 1);
    wait_to(167);
    chk("conf_off_a", int'(a_cf), 0);
    chk("conf_off_b", int'(b_cf), 0);

    // async reset mid-hold
    wait_to(180);
    btn1 = 1'b1;
    both(187, 1'b1);
    wait_to(190);
    rst_n = 1'b0;
    #1;
    chk("arst_held_a", int'(a_held), 0);
    chk("arst_held_b", int'(b_held), 0);
    chk("arst_conf", int'(b_cf), 0);
    wait_to(192);
    rst_n = 1'b1;
    both(199, 1'b1);
    wait_to(202);
    btn1 = 1'b0;

    // direct left-to-right switch in one cycle
    wait_to(220);
    btn1 = 1'b1;
    both(227, 1'b1);
    wait_to(230);
    btn1 = 1'b0;
    btn2 = 1'b1;
    both(237, 1'b0);
    wait_to(235);
    chk("switch_held_l", int'(a_held), 2);
    wait_to(236);
    chk("switch_held_r", int'(a_held), 1);
    wait_to(240);
    btn2 = 1'b0;

    wait_to(260);
    chk("drain_a", q[0].size(), 0);
    chk("drain_b", q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
